multicycle_controller_param: RTL and testbench
==============================================

Name: multicycle_controller_param

Overview:
- Next-generation multicycle computer controller: one FSM with integrated ALU decode, condition check and flag-update enable.
- Adds a memory ready/request handshake with configurable wait-state timeout, a sticky fault state and performance counters.
- Sits between the instruction register/flags of the multicycle datapath and its mux/enable controls.
- Datapath must tolerate variable-latency memory.

Parameters:
- INSTR_W, 32, instruction width; fields below are fixed positions, so it must be ≥32.
- WAIT_W, 4, width of the wait-state counter.
- MAX_WAIT, 15, cycles with mem_ready low before fault; must be ≤2^WAIT_W−1 and ≥1.
- CNT_W, 32, width of the cycle/retired-instruction counters.
- HAS_LINK, 1, 1 = branch bit24 writes the link register (R14); 0 = bit24 ignored.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- INSTRUCTION  in  INSTR_W  IR contents: [31:28] cond, [27:26] op, [25] I, [24:21] cmd, [20] S/L, [24] link for branches
- FLAGS  in  4  NZCV from xPSR, [3]=N … [0]=V
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, FlagUpdate, A3Src, WD3Src  out  1 each  datapath enables/selects
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects
- ALUop  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV
- state  out  4  current FSM state
- fault  out  1  sticky memory-timeout indication
- cycle_count, instr_count  out  CNT_W  free-running cycles / retired instructions

Behaviour:
- Reset (asynchronous, active-low): state=FETCH(0), wait counter=0, fault=0, both counters=0.
- While reset is asserted, all enables and mem_req are 0. Outputs are Moore-decoded from state except where noted.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, FAULT=10. Codes 11–15 go to FETCH.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUop=ADD, ResultSrc=10.
  - IRWrite and PCWrite = mem_ready (Mealy); go to DECODE when mem_ready=1, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=10 (PC+8 precompute). Condition check on INSTRUCTION[31:28] against FLAGS uses ARM encodings 0–14; 15 is treated as never.
  - Condition fails → FETCH; instruction retires (instr_count+1).
  - op=00 → EXECI if I=1, else EXECR.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=11 → FETCH, not retired.
- EXECR/EXECI: ALUSrcB=00 (register) or 01 (immediate); ALUop from cmd.
  - cmd map: 0100→ADD, 0010/1010→SUB, 0000→AND, 1100→ORR, 0001→EOR, 1101→MOV; others→ADD.
  - FlagUpdate=S (cmd 1010 forces FlagUpdate=1).
  - Next: cmd 1010 → FETCH (retire), else → ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00; → FETCH, retire.
- MEMADR: ALUSrcB=01, ALUop=ADD; L=1 → MEMRD, L=0 → MEMWR.
- MEMRD: mem_req=1, AdrSrc=1; mem_ready → MEMWB.
- MEMWR: mem_req=1, AdrSrc=1, MemWrite=mem_ready (Mealy); mem_ready → FETCH, retire.
- MEMWB: RegWrite=1, ResultSrc=01; → FETCH, retire.
- BRANCH: PCWrite=1, ALUSrcB=01, ResultSrc=10.
  - If HAS_LINK and bit24: RegWrite=1, A3Src=1, WD3Src=1.
  - → FETCH, retire.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1.
  - Increments each cycle in those states with mem_ready=0.
  - When counter == MAX_WAIT−1 and mem_ready=0, the next state is FAULT.
- FAULT: all enables 0, mem_req=0, fault=1. Absorbing until reset; cycle_count keeps counting.
- Counters: cycle_count increments every cycle out of reset. Both counters wrap modulo 2^CNT_W and do not saturate.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Shared package multicycle_ctrl_pkg holds: state encodings, ALUop codes, cond/cmd codes, mux-select constants.
- One sub-module: multicycle_ctrl_cond_check (combinational cond/FLAGS → pass), reusable by later pipelines.

Test Plan:
- Reset low mid-MEMRD → state=0, counters=0, all enables 0 immediately.
- ADD R1,R2,#5 (0xE2821005), mem_ready=1 always → states 0,1,7,8,0; EXECI ALUop=000, ALUSrcB=01; instr_count=1 after 4 cycles.
- LDR (0xE5921000), mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles, then 4, 0; RegWrite only in MEMWB.
- CMP with S (0xE3510000) → EXECI FlagUpdate=1, ALUop=001, no ALUWB; BLNE (0x1B000002) with Z=1 → DECODE→FETCH, retired, no PCWrite in decode.
- BL (0xEB000004), HAS_LINK=1 → BRANCH asserts PCWrite, RegWrite, A3Src, WD3Src; with HAS_LINK=0 RegWrite=0.
- mem_ready held 0 in FETCH, MAX_WAIT=15 → FAULT entered after 15 cycles, fault=1 sticky, mem_req=0; only reset exits.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle controller
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_FAULT  = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Data-processing cmd field to ALU operation; unlisted commands fall back to ADD
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            CMD_EOR:          return ALU_EOR;
            CMD_MOV:          return ALU_MOV;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// rtl/multicycle_ctrl_cond_check.sv - ARM condition field evaluation against NZCV
module multicycle_ctrl_cond_check
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    // Code 15 is treated as never-execute
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller_param.sv
// rtl/multicycle_controller_param.sv - multicycle controller FSM with memory handshake and timeout fault
module multicycle_controller_param
    import multicycle_ctrl_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32,
    parameter int HAS_LINK = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic [3:0]         FLAGS,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               FlagUpdate,
    output logic               A3Src,
    output logic               WD3Src,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [2:0]         ALUop,
    output logic [3:0]         state,
    output logic               fault,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cycle_q, instr_q;
    logic               retire, in_wait, timeout, cond_pass;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       imm, sl, link;
    logic       unused_instr;

    assign op   = INSTRUCTION[27:26];
    assign imm  = INSTRUCTION[25];
    assign cmd  = INSTRUCTION[24:21];
    assign sl   = INSTRUCTION[20];
    assign link = (HAS_LINK != 0) && INSTRUCTION[24];
    assign unused_instr = ^INSTRUCTION;

    multicycle_ctrl_cond_check u_cond (
        .cond_i  (INSTRUCTION[31:28]),
        .flags_i (FLAGS),
        .pass_o  (cond_pass)
    );

    // Only the memory-access states wait on mem_ready; any completed access restarts the count
    assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    assign timeout = in_wait && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign wait_d  = (in_wait && !mem_ready) ? wait_q + WAIT_W'(1) : '0;

    // State, wait counter and free-running performance counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_q + CNT_W'(1);
            instr_q <= instr_q + CNT_W'(retire);
        end
    end

    // Next state and retirement strobe
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (timeout)        state_d = ST_FAULT;
                else if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!cond_pass) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    case (op)
                        OP_DP:   state_d = imm ? ST_EXECI : ST_EXECR;
                        OP_MEM:  state_d = ST_MEMADR;
                        OP_BR:   state_d = ST_BRANCH;
                        default: state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXECR, ST_EXECI: begin
                if (cmd == CMD_CMP) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_ALUWB;
                end
            end
            ST_MEMADR: state_d = sl ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (timeout)        state_d = ST_FAULT;
                else if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWR: begin
                if (timeout) begin
                    state_d = ST_FAULT;
                end else if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_ALUWB, ST_MEMWB, ST_BRANCH: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Datapath controls, forced idle while reset is held
    always_comb begin
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        FlagUpdate = 1'b0;
        A3Src      = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUop      = ALU_ADD;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
                ST_DECODE: begin
                    ALUSrcA = SRCA_PC;
                    ALUSrcB = SRCB_FOUR;
                end
                ST_EXECR, ST_EXECI: begin
                    ALUSrcB    = (state_q == ST_EXECI) ? SRCB_IMM : SRCB_REG;
                    ALUop      = alu_decode(cmd);
                    FlagUpdate = sl || (cmd == CMD_CMP);
                end
                ST_ALUWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_ALUOUT;
                end
                ST_MEMADR: ALUSrcB = SRCB_IMM;
                ST_MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                ST_MEMWR: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ready;
                end
                ST_MEMWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_DATA;
                end
                ST_BRANCH: begin
                    PCWrite   = 1'b1;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALU;
                    RegWrite  = link;
                    A3Src     = link;
                    WD3Src    = link;
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign fault       = (state_q == ST_FAULT);
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_multicycle_controller_param.sv
// tb/tb_multicycle_controller_param.sv - scoreboard bench for multicycle_controller_param
module tb_multicycle_controller_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [3:0]  FLAGS;
    logic        mem_ready;

    logic        mem_req, IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, FlagUpdate, A3Src, WD3Src, fault;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ALUop;
    logic [3:0]  state;
    logic [31:0] cycle_count, instr_count;

    logic        nl_mem_req, nl_IRWrite, nl_PCWrite, nl_AdrSrc, nl_MemWrite, nl_RegWrite, nl_FlagUpdate;
    logic        nl_A3Src, nl_WD3Src, nl_fault;
    logic [1:0]  nl_ALUSrcA, nl_ALUSrcB, nl_ResultSrc;
    logic [2:0]  nl_ALUop;
    logic [3:0]  nl_state;
    logic [31:0] nl_cycle_count, nl_instr_count;

    always #5 clock = ~clock;

    multicycle_controller_param dut (
        .clock(clock), .reset(reset), .INSTRUCTION(INSTRUCTION), .FLAGS(FLAGS), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .FlagUpdate(FlagUpdate), .A3Src(A3Src), .WD3Src(WD3Src),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUop(ALUop),
        .state(state), .fault(fault), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    multicycle_controller_param #(.HAS_LINK(0)) u_nolink (
        .clock(clock), .reset(reset), .INSTRUCTION(INSTRUCTION), .FLAGS(FLAGS), .mem_ready(mem_ready),
        .mem_req(nl_mem_req), .IRWrite(nl_IRWrite), .PCWrite(nl_PCWrite), .AdrSrc(nl_AdrSrc),
        .MemWrite(nl_MemWrite), .RegWrite(nl_RegWrite), .FlagUpdate(nl_FlagUpdate), .A3Src(nl_A3Src),
        .WD3Src(nl_WD3Src), .ALUSrcA(nl_ALUSrcA), .ALUSrcB(nl_ALUSrcB), .ResultSrc(nl_ResultSrc),
        .ALUop(nl_ALUop), .state(nl_state), .fault(nl_fault), .cycle_count(nl_cycle_count),
        .instr_count(nl_instr_count)
    );

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] ic;
        logic [31:0] cc;
        logic [2:0]  nl;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_exp = 0;
    int unsigned ic_exp = 0;

    logic [18:0] C_RST, C_FETCH1, C_FETCH0, C_DECODE, C_EXECI_ADD, C_EXECI_CMP, C_ALUWB;
    logic [18:0] C_MEMADR, C_MEMRD, C_MEMWB, C_MEMWR0, C_MEMWR1, C_BRL, C_FAULT;

    // {mem_req,IRWrite,PCWrite,AdrSrc,MemWrite,RegWrite,FlagUpdate,A3Src,WD3Src,ALUSrcA,ALUSrcB,ResultSrc,ALUop,fault}
    function automatic logic [18:0] mk(input logic req, irw, pcw, adr, mw, rw, fu, a3, wd3,
                                       input logic [1:0] sa, sb, rs, input logic [2:0] alu, input logic flt);
        return {req, irw, pcw, adr, mw, rw, fu, a3, wd3, sa, sb, rs, alu, flt};
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: actual %0h required %0h", tag, what, act, req);
        end
    endtask

    // Queue this cycle's expected response, then advance one clock
    task automatic step(input string tag, input logic [3:0] st, input logic [18:0] ctl, input bit ret);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        e.ic  = ic_exp;
        e.cc  = cyc_exp;
        e.nl  = (st == 4'd9) ? 3'b000 : {ctl[13], ctl[11], ctl[10]};
        exp_q.push_back(e);
        @(posedge clock);
        if (reset) cyc_exp++;
        if (ret) ic_exp++;
        #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation
    initial begin
        exp_t        e;
        logic [18:0] act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {mem_req, IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite, FlagUpdate, A3Src, WD3Src,
                       ALUSrcA, ALUSrcB, ResultSrc, ALUop, fault};
                cmp(e.tag, "state", {28'd0, state}, {28'd0, e.st});
                cmp(e.tag, "ctl", {13'd0, act}, {13'd0, e.ctl});
                cmp(e.tag, "instr_count", instr_count, e.ic);
                cmp(e.tag, "cycle_count", cycle_count, e.cc);
                cmp(e.tag, "nolink_rw_a3_wd3", {29'd0, nl_RegWrite, nl_A3Src, nl_WD3Src}, {29'd0, e.nl});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        C_RST       = '0;
        C_FETCH1    = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000, 0);
        C_FETCH0    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000, 0);
        C_DECODE    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        C_EXECI_ADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000, 0);
        C_EXECI_CMP = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 3'b001, 0);
        C_ALUWB     = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        C_MEMADR    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000, 0);
        C_MEMRD     = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        C_MEMWB     = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0);
        C_MEMWR0    = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        C_MEMWR1    = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        C_BRL       = mk(0, 0, 1, 0, 0, 1, 0, 1, 1, 2'b00, 2'b01, 2'b10, 3'b000, 0);
        C_FAULT     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);

        INSTRUCTION = 32'h0;
        FLAGS       = 4'h0;
        mem_ready   = 1'b0;
        @(posedge clock);
        #1;
        step("rst0", 4'd0, C_RST, 0);
        step("rst1", 4'd0, C_RST, 0);
        reset = 1'b1;

        // ADD R1,R2,#5
        INSTRUCTION = 32'hE2821005;
        mem_ready   = 1'b1;
        step("add_f", 4'd0, C_FETCH1, 0);
        step("add_d", 4'd1, C_DECODE, 0);
        step("add_x", 4'd7, C_EXECI_ADD, 0);
        step("add_wb", 4'd8, C_ALUWB, 1);

        // LDR with three wait states
        INSTRUCTION = 32'hE5921000;
        step("ldr_f", 4'd0, C_FETCH1, 0);
        step("ldr_d", 4'd1, C_DECODE, 0);
        step("ldr_a", 4'd2, C_MEMADR, 0);
        mem_ready = 1'b0;
        repeat (3) step("ldr_rdw", 4'd3, C_MEMRD, 0);
        mem_ready = 1'b1;
        step("ldr_rd", 4'd3, C_MEMRD, 0);
        step("ldr_wb", 4'd4, C_MEMWB, 1);

        // CMP R1,#0
        INSTRUCTION = 32'hE3510000;
        step("cmp_f", 4'd0, C_FETCH1, 0);
        step("cmp_d", 4'd1, C_DECODE, 0);
        step("cmp_x", 4'd7, C_EXECI_CMP, 1);

        // BLNE with Z set: condition fails in decode
        INSTRUCTION = 32'h1B000002;
        FLAGS       = 4'b0100;
        step("blne_f", 4'd0, C_FETCH1, 0);
        step("blne_d", 4'd1, C_DECODE, 1);

        // BL
        INSTRUCTION = 32'hEB000004;
        FLAGS       = 4'b0000;
        step("bl_f", 4'd0, C_FETCH1, 0);
        step("bl_d", 4'd1, C_DECODE, 0);
        step("bl_br", 4'd9, C_BRL, 1);

        // STR with one wait state
        INSTRUCTION = 32'hE5821000;
        step("str_f", 4'd0, C_FETCH1, 0);
        step("str_d", 4'd1, C_DECODE, 0);
        step("str_a", 4'd2, C_MEMADR, 0);
        mem_ready = 1'b0;
        step("str_w0", 4'd5, C_MEMWR0, 0);
        mem_ready = 1'b1;
        step("str_w1", 4'd5, C_MEMWR1, 1);

        // op=11: back to fetch without retiring; mem_ready ignored in decode
        INSTRUCTION = 32'hEC000000;
        step("op3_f", 4'd0, C_FETCH1, 0);
        mem_ready = 1'b0;
        step("op3_d", 4'd1, C_DECODE, 0);

        // cond=1111 never executes but retires
        mem_ready   = 1'b1;
        INSTRUCTION = 32'hF2821005;
        step("nv_f", 4'd0, C_FETCH1, 0);
        step("nv_d", 4'd1, C_DECODE, 1);

        // Fetch timeout: 15 stalled cycles, then sticky fault
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step("to_fetch", 4'd0, C_FETCH0, 0);
        mem_ready = 1'b1;
        repeat (3) step("to_fault", 4'd10, C_FAULT, 0);

        // Reset leaves fault
        reset   = 1'b0;
        cyc_exp = 0;
        ic_exp  = 0;
        step("rst_flt", 4'd0, C_RST, 0);
        reset = 1'b1;

        // Reset asserted mid-MEMRD takes effect immediately
        INSTRUCTION = 32'hE5921000;
        mem_ready   = 1'b1;
        step("ldr2_f", 4'd0, C_FETCH1, 0);
        step("ldr2_d", 4'd1, C_DECODE, 0);
        step("ldr2_a", 4'd2, C_MEMADR, 0);
        mem_ready = 1'b0;
        step("ldr2_rd", 4'd3, C_MEMRD, 0);
        reset   = 1'b0;
        cyc_exp = 0;
        ic_exp  = 0;
        step("rst_mid", 4'd0, C_RST, 0);
        reset = 1'b1;
        step("post_f", 4'd0, C_FETCH0, 0);

        repeat (2) @(posedge clock);
        cmp("drain", "queue_left", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
